// File: rtl/esdi_nrz_deserializer_if.sv
// AXI-Stream byte channel out of the ESDI NRZ deserializer.
//   tvalid/tdata/tlast/tuser : driven by the master (the deserializer)
//   tready                   : driven by the slave (capture FIFO / DMA)
//   tuser                    : frame-error flag, meaningful on the tlast beat only
interface esdi_nrz_deserializer_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;
  logic       tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/esdi_nrz_deserializer.sv
// ESDI NRZ read-data deserializer.
// Samples the drive's asynchronous NRZ read clock/data in the aclk domain while the read
// gate is active, hunts for the sync byte, then packs following bits MSB-first into bytes
// and streams them out, one frame per read-gate window with tlast on the final byte.
//
// Ports:
//   aclk, areset      : system clock, synchronous active-high reset
//   esdi_read_gate    : read gate (aclk domain, delayed to stay aligned with synced data)
//   esdi_read_clock   : asynchronous NRZ read clock, data valid at its rising edge
//   esdi_read_data    : asynchronous NRZ read data
//   m                 : AXI-Stream master (tuser = frame error on the tlast beat)
//   sync_error        : one-cycle pulse when the sync byte is not found
//   overflow          : sticky, set when a byte is dropped; cleared by clear_status
//   clear_status      : clears overflow (wins over a same-cycle set)
//   frame_bytes       : bytes accepted in the current/most recent frame, saturating
module esdi_nrz_deserializer #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hFE,
  parameter logic [15:0] SYNC_TIMEOUT = 16'd1024,
  parameter int unsigned SYNC_STAGES  = 3          // must be >= 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          esdi_read_gate,
  input  logic                          esdi_read_clock,
  input  logic                          esdi_read_data,
  esdi_nrz_deserializer_if.master       m,
  output logic                          sync_error,
  output logic                          overflow,
  input  logic                          clear_status,
  output logic [15:0]                   frame_bytes
);

  typedef enum logic [2:0] {StIdle, StHunt, StNosync, StData, StFlush} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q, gate_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, gate_s, rd_edge;

  logic [7:0]  shift_q, shift_d, new_shift;
  logic [15:0] hunt_q, hunt_d, hunt_next;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        ferr_q, ferr_d;
  logic [15:0] frame_bytes_q, frame_bytes_d;
  logic        overflow_q, overflow_d, ovf_set;
  logic        sync_err_q, sync_err_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        push, push_last, push_user, slot_free;

  // All three inputs get the same depth so the gate edge stays aligned with the data.
  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign gate_s  = gate_sync_q[SYNC_STAGES-1];
  assign rd_edge = clk_s & ~clk_prev_q;

  assign new_shift = {shift_q[6:0], data_s};
  assign hunt_next = hunt_q + 16'd1;
  assign slot_free = ~tvalid_q | m.tready;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    hunt_d        = hunt_q;
    bitcnt_d      = bitcnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    ferr_d        = ferr_q;
    frame_bytes_d = frame_bytes_q;
    sync_err_d    = 1'b0;
    ovf_set       = 1'b0;
    push          = 1'b0;
    push_last     = 1'b0;
    push_user     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gate_s) begin
          shift_d = 8'd0;
          hunt_d  = 16'd0;
          state_d = StHunt;
        end
      end
      StHunt: begin
        // A gate drop ends the hunt unconditionally.
        if (!gate_s) begin
          sync_err_d = 1'b1;
          state_d    = StIdle;
        end else if (rd_edge) begin
          shift_d = new_shift;
          hunt_d  = hunt_next;
          if (new_shift == SYNC_BYTE) begin
            state_d       = StData;
            bitcnt_d      = 3'd0;
            frame_bytes_d = 16'd0;
            ferr_d        = 1'b0;
          end else if (hunt_next >= SYNC_TIMEOUT) begin
            sync_err_d = 1'b1;
            state_d    = StNosync;
          end
        end
      end
      StNosync: begin
        if (!gate_s) state_d = StIdle;
      end
      StData: begin
        if (rd_edge) begin
          shift_d  = new_shift;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            // The held byte is only known not to be last once its successor completes.
            if (hold_full_q) begin
              if (slot_free) begin
                push = 1'b1;
              end else begin
                ovf_set = 1'b1;
                ferr_d  = 1'b1;
              end
            end
            hold_d        = new_shift;
            hold_full_d   = 1'b1;
            frame_bytes_d = (frame_bytes_q != 16'hFFFF) ? frame_bytes_q + 16'd1 : frame_bytes_q;
          end
        end
        // Edge in the same cycle is already folded into bitcnt_d/hold_full_d.
        if (!gate_s) begin
          if (bitcnt_d != 3'd0) ferr_d = 1'b1;
          state_d = hold_full_d ? StFlush : StIdle;
        end
      end
      StFlush: begin
        if (slot_free) begin
          push        = 1'b1;
          push_last   = 1'b1;
          push_user   = ferr_q;
          hold_full_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (push) begin
      tvalid_d = 1'b1;
      tdata_d  = hold_q;
      tlast_d  = push_last;
      tuser_d  = push_user;
    end else if (m.tready) begin
      tvalid_d = 1'b0;
    end

    overflow_d = clear_status ? 1'b0 : (overflow_q | ovf_set);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      clk_sync_q    <= '0;
      data_sync_q   <= '0;
      gate_sync_q   <= '0;
      clk_prev_q    <= 1'b0;
      state_q       <= StIdle;
      shift_q       <= 8'd0;
      hunt_q        <= 16'd0;
      bitcnt_q      <= 3'd0;
      hold_q        <= 8'd0;
      hold_full_q   <= 1'b0;
      ferr_q        <= 1'b0;
      frame_bytes_q <= 16'd0;
      overflow_q    <= 1'b0;
      sync_err_q    <= 1'b0;
      tvalid_q      <= 1'b0;
      tdata_q       <= 8'd0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
    end else begin
      clk_sync_q    <= {clk_sync_q[SYNC_STAGES-2:0], esdi_read_clock};
      data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], esdi_read_data};
      gate_sync_q   <= {gate_sync_q[SYNC_STAGES-2:0], esdi_read_gate};
      clk_prev_q    <= clk_s;
      state_q       <= state_d;
      shift_q       <= shift_d;
      hunt_q        <= hunt_d;
      bitcnt_q      <= bitcnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      ferr_q        <= ferr_d;
      frame_bytes_q <= frame_bytes_d;
      overflow_q    <= overflow_d;
      sync_err_q    <= sync_err_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
    end
  end

  assign m.tvalid    = tvalid_q;
  assign m.tdata     = tdata_q;
  assign m.tlast     = tlast_q;
  assign m.tuser     = tuser_q;
  assign sync_error  = sync_err_q;
  assign overflow    = overflow_q;
  assign frame_bytes = frame_bytes_q;

endmodule
